t01_ai_feature_scan: RTL

T01_AI_FEATURE_SCAN -- requirements
Module: t01_ai_feature_scan

---
 rtl/t01_ai_pkg.sv | 13 +
 rtl/t01_ai_column_eval.sv | 25 ++
 rtl/t01_ai_feature_scan.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/t01_ai_pkg.sv
// Shared types and default board geometry for the Tetris-AI feature scanner.
package t01_ai_pkg;
  localparam int COLS_DEF = 10;
  localparam int ROWS_DEF = 20;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SCAN_COLS = 3'd1,
    SCAN_ROWS = 3'd2,
    SCORE     = 3'd3,
    DONE      = 3'd4
  } state_e;
endpackage

// File: rtl/t01_ai_column_eval.sv
// Combinational height/holes evaluation of one board column (bit 0 = bottom row).
module t01_ai_column_eval
  import t01_ai_pkg::*;
#(
  parameter int ROWS = ROWS_DEF
) (
  input  logic [ROWS-1:0]              i_col,
  output logic [$clog2(ROWS+1)-1:0]    o_height,
  output logic [$clog2(ROWS+1)-1:0]    o_holes
);
  localparam int HW = $clog2(ROWS+1);

  logic [HW-1:0] w_ones;

  // Every set cell lies at or below the top one, so holes = height - popcount.
  always_comb begin
    o_height = '0;
    w_ones   = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (i_col[r]) o_height = HW'(r + 1);
      w_ones = w_ones + HW'(i_col[r]);
    end
    o_holes = o_height - w_ones;
  end
endmodule

// File: rtl/t01_ai_feature_scan.sv
// Sequential board feature extractor (heights, holes, bumpiness, full rows).
// Optional weighted score enabled by defining T01_AI_SCORE_EN.
module t01_ai_feature_scan
  import t01_ai_pkg::*;
#(
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int SUM_W  = 8,
  parameter int W_LINE = 8,
  parameter int W_HOLE = 4,
  parameter int W_BUMP = 1,
  parameter int W_HGT  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [COLS*ROWS-1:0]       board,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(ROWS+1)-1:0]  lines_cleared,
  output logic [$clog2(ROWS+1)-1:0]  max_height,
  output logic [SUM_W-1:0]           holes,
  output logic [SUM_W-1:0]           bumpiness,
  output logic [SUM_W-1:0]           height_sum,
  output logic [15:0]                score
);
  localparam int HW   = $clog2(ROWS+1);
  localparam int NMAX = (COLS > ROWS) ? COLS : ROWS;
  localparam int IW   = $clog2(NMAX+1);

  state_e                r_state;
  logic [COLS*ROWS-1:0]  r_snap;
  logic [IW-1:0]         r_idx;
  logic [HW-1:0]         r_prev_h, r_acc_maxh, r_acc_lines;
  logic [SUM_W-1:0]      r_acc_holes, r_acc_bump, r_acc_hsum;
  logic [HW-1:0]         r_lines, r_maxh;
  logic [SUM_W-1:0]      r_holes, r_bump, r_hsum;

  logic [ROWS-1:0]       w_col;
  logic [HW-1:0]         w_h, w_holes, w_diff;
  logic                  w_row_full;
  int                    w_c, w_r;

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [HW-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + (SUM_W+1)'(b);
    return s[SUM_W] ? '1 : s[SUM_W-1:0];
  endfunction

  // Column/row selects are clamped so the idle half of the scan never indexes out of range.
  always_comb begin
    w_c = (int'(r_idx) < COLS) ? int'(r_idx) : 0;
    w_r = (int'(r_idx) < ROWS) ? int'(r_idx) : 0;
    for (int r = 0; r < ROWS; r++) w_col[r] = r_snap[r*COLS + w_c];
    w_row_full = &r_snap[w_r*COLS +: COLS];
    w_diff = (w_h >= r_prev_h) ? (w_h - r_prev_h) : (r_prev_h - w_h);
  end

  t01_ai_column_eval #(.ROWS(ROWS)) u_col (
    .i_col   (w_col),
    .o_height(w_h),
    .o_holes (w_holes)
  );

`ifdef T01_AI_SCORE_EN
  int          w_raw;
  logic [15:0] w_score, r_score;
  always_comb begin
    w_raw = W_LINE * int'(r_acc_lines) - W_HOLE * int'(r_acc_holes)
          - W_BUMP * int'(r_acc_bump)  - W_HGT  * int'(r_acc_hsum);
    if (w_raw > 32767)       w_score = 16'h7fff;
    else if (w_raw < -32768) w_score = 16'h8000;
    else                     w_score = w_raw[15:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_score <= '0;
    else if (r_state == SCORE && !abort)      r_score <= w_score;
  end
  assign score = r_score;
`else
  assign score = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_snap      <= '0;
      r_idx       <= '0;
      r_prev_h    <= '0;
      r_acc_maxh  <= '0;
      r_acc_lines <= '0;
      r_acc_holes <= '0;
      r_acc_bump  <= '0;
      r_acc_hsum  <= '0;
      r_lines     <= '0;
      r_maxh      <= '0;
      r_holes     <= '0;
      r_bump      <= '0;
      r_hsum      <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) begin
          r_snap      <= board;
          r_idx       <= '0;
          r_prev_h    <= '0;
          r_acc_maxh  <= '0;
          r_acc_lines <= '0;
          r_acc_holes <= '0;
          r_acc_bump  <= '0;
          r_acc_hsum  <= '0;
          r_state     <= SCAN_COLS;
        end
        SCAN_COLS: if (abort) r_state <= IDLE;
        else begin
          r_acc_hsum  <= sat_add(r_acc_hsum, w_h);
          r_acc_holes <= sat_add(r_acc_holes, w_holes);
          if (w_h > r_acc_maxh) r_acc_maxh <= w_h;
          if (r_idx != '0) r_acc_bump <= sat_add(r_acc_bump, w_diff);
          r_prev_h <= w_h;
          if (r_idx == IW'(COLS-1)) begin
            r_idx   <= '0;
            r_state <= SCAN_ROWS;
          end else r_idx <= r_idx + 1'b1;
        end
        SCAN_ROWS: if (abort) r_state <= IDLE;
        else begin
          if (w_row_full) r_acc_lines <= r_acc_lines + 1'b1;
          if (r_idx == IW'(ROWS-1)) begin
            r_idx   <= '0;
            r_state <= SCORE;
          end else r_idx <= r_idx + 1'b1;
        end
        SCORE: if (abort) r_state <= IDLE;
        else begin
          r_lines <= r_acc_lines;
          r_maxh  <= r_acc_maxh;
          r_holes <= r_acc_holes;
          r_bump  <= r_acc_bump;
          r_hsum  <= r_acc_hsum;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy          = (r_state == SCAN_COLS) || (r_state == SCAN_ROWS) || (r_state == SCORE);
  assign done          = (r_state == DONE);
  assign lines_cleared = r_lines;
  assign max_height    = r_maxh;
  assign holes         = r_holes;
  assign bumpiness     = r_bump;
  assign height_sum    = r_hsum;
endmodule
